// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter sharing one 32:1 single-bit mux among 32 requesters.
// Grants are registered, bounded to MAX_HOLD cycles, and followed by one idle bubble.
module mux32_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req,
  input  logic        done,
  input  logic        mux_out,
  output logic [4:0]  sel,
  output logic [31:0] grant,
  output logic        valid,
  output logic        data,
  output logic        expired
);

  // Handshake: a requester holds req[i] high until served; the owner keeps
  // req[sel] high while it wants the mux and pulses done for one cycle to release.
  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [4:0]        ptr_q, ptr_d;
  logic [4:0]        sel_q, sel_d;
  logic [31:0]       grant_q, grant_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              expired_q, expired_d;
  logic [4:0]        win;
  logic [4:0]        idx;

  // Scan from the farthest offset down so the set bit closest to ptr wins.
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int i = 31; i >= 0; i--) begin
      idx = ptr_q + 5'(i);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 32'd0) begin
          state_d = BUSY;
          sel_d   = win;
          grant_d = 32'd1 << win;
          cnt_d   = HOLD_W'(1);
        end
      end
      BUSY: begin
        if (!req[sel_q] || done || (cnt_q == HOLD_W'(MAX_HOLD))) begin
          // A done arriving with the tenure limit counts as a normal release.
          expired_d = req[sel_q] && !done;
          state_d   = IDLE;
          ptr_d     = sel_q + 5'd1;
          grant_d   = 32'd0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 5'd0;
      sel_q     <= 5'd0;
      grant_q   <= 32'd0;
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign valid   = (state_q == BUSY);
  assign expired = expired_q;
  assign data    = mux_out & valid;

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Self-checking bench for mux32_rr_arbiter: a reference model pushes expected
// outputs per cycle into a queue that is popped and compared after each edge.
module tb_mux32_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic        done;
  logic        mux_out;
  logic [4:0]  sel;
  logic [31:0] grant;
  logic        valid;
  logic        data;
  logic        expired;

  mux32_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .mux_out(mux_out),
    .sel(sel), .grant(grant), .valid(valid), .data(data), .expired(expired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp_q[$];

  // reference model
  logic       m_busy;
  int         m_sel, m_ptr, m_cnt;
  logic       m_exp;

  task automatic check_val(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_exp = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] r, input logic d);
    int found;
    m_exp = 1'b0;
    if (!m_busy) begin
      found = -1;
      for (int i = 0; i < 32; i++)
        if (found < 0 && r[(m_ptr + i) % 32]) found = (m_ptr + i) % 32;
      if (found >= 0) begin
        m_busy = 1'b1; m_sel = found; m_cnt = 1;
      end
    end else if (!r[m_sel] || d || m_cnt == MAX_HOLD) begin
      m_exp  = r[m_sel] && !d;
      m_busy = 1'b0;
      m_ptr  = (m_sel + 1) % 32;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [39:0] model_out(input logic m);
    logic [31:0] g;
    g = m_busy ? (32'd1 << m_sel) : 32'd0;
    return {5'(m_sel), g, m_busy, m_exp, m & m_busy};
  endfunction

  // driver: called at negedge, checks the outputs #1 after the following posedge
  task automatic drive_cycle(input logic [31:0] r, input logic d, input logic m, input string tag);
    logic [39:0] e;
    req = r; done = d; mux_out = m;
    model_step(r, d);
    exp_q.push_back(model_out(m));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val(tag, {sel, grant, valid, expired, data}, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = 1'b0; mux_out = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    check_val("reset_outputs", {sel, grant, valid, expired, data}, 40'd0);
    @(negedge clk);

    // 1: single requester, tenure expiry, bubble, re-grant
    drive_cycle(32'h1, 1'b0, 1'b0, "t1_first");
    check_val("t1_grant", {8'd0, grant}, {8'd0, 32'h1});
    for (int c = 0; c < 11; c++) drive_cycle(32'h1, 1'b0, 1'b0, "t1_hold");

    // 2: two requesters alternate with done in each grant's 2nd cycle
    do_reset();
    for (int c = 0; c < 14; c++)
      drive_cycle(32'h8000_0001, m_busy && m_cnt == 2, 1'b0, "t2_alt");

    // 3: pointer wrap from 31 to 0
    do_reset();
    drive_cycle(32'h8000_0000, 1'b0, 1'b0, "t3_g31");
    drive_cycle(32'h8000_0000, 1'b1, 1'b0, "t3_rel31");
    drive_cycle(32'h6, 1'b0, 1'b0, "t3_g1");
    check_val("t3_sel1", {35'd0, sel}, 40'd1);
    for (int c = 0; c < 5; c++) drive_cycle(32'h6, m_busy && m_cnt == 1, 1'b0, "t3_seq");

    // 4: owner drops its request mid-tenure
    do_reset();
    drive_cycle(32'h20, 1'b0, 1'b0, "t4_g5");
    drive_cycle(32'h20, 1'b0, 1'b0, "t4_c2");
    drive_cycle(32'h20, 1'b0, 1'b0, "t4_c3");
    drive_cycle(32'h0, 1'b0, 1'b0, "t4_drop");
    check_val("t4_no_expire", {39'd0, expired}, 40'd0);
    drive_cycle(32'hFFFF_FFFF, 1'b0, 1'b0, "t4_ptr");
    check_val("t4_next_sel6", {35'd0, sel}, 40'd6);

    // 5: data path follows mux_out only while valid
    do_reset();
    drive_cycle(32'h80, 1'b0, 1'b0, "t5_g7");
    drive_cycle(32'h80, 1'b0, 1'b1, "t5_d1");
    drive_cycle(32'h80, 1'b0, 1'b1, "t5_d2");
    drive_cycle(32'h80, 1'b0, 1'b0, "t5_d3");
    drive_cycle(32'h0, 1'b0, 1'b1, "t5_idle1");
    drive_cycle(32'h0, 1'b0, 1'b1, "t5_idle2");
    check_val("t5_data_idle", {39'd0, data}, 40'd0);

    // 6: async reset mid-grant
    do_reset();
    drive_cycle(32'h1000, 1'b0, 1'b0, "t6_g12");
    for (int c = 0; c < 3; c++) drive_cycle(32'h1000, 1'b0, 1'b0, "t6_hold");
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_async", {sel, grant, valid, expired, data}, 40'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(32'h1001, 1'b0, 1'b0, "t6_after");
    check_val("t6_sel0", {35'd0, sel}, 40'd0);

    // random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] r;
      r = 32'd0;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1)) r[$urandom_range(0, 31)] = 1'b1;
      if (m_busy && $urandom_range(0, 3) != 0) r[m_sel] = 1'b1;
      drive_cycle(r, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux32_rr_arbiter.md
Name: mux32_rr_arbiter

Overview:
Round-robin arbiter that shares one 32:1 single-bit mux between 32 requesters. It drives the mux's 5-bit select and a one-hot grant vector. It bounds each grant to a maximum tenure so no requester can starve the others. It sits between the requesting agents and the mux select input, and consumes the mux output only as pass-through data.

Parameters:
MAX_HOLD, 8, maximum cycles a single grant is held before forced release (legal range 1..255)
HOLD_W, 8, width of the tenure counter; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  32  request vector, bit i = requester i wants the mux
done  input  1  single-cycle release pulse from the current owner
mux_out  input  1  output bit of the 32:1 mux (driven by sel)
sel  output  5  registered mux select = index of current owner
grant  output  32  registered one-hot grant, all-zero when idle
valid  output  1  high while a grant is active
data  output  1  mux_out gated by valid (0 when idle)
expired  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (async on rst_n low, released synchronously by clk domain logic): state=IDLE, sel=0, grant=0, valid=0, expired=0, hold counter=0, priority pointer ptr=0.
- State machine has 2 states, IDLE and BUSY.
- IDLE, req==0: stay in IDLE, all outputs at their idle values.
- IDLE, req!=0: choose the winner w = first set bit of req searching ptr, ptr+1, ..., 31, 0, ..., ptr-1 (mod 32).
  - At the next edge: sel=w, grant=1<<w, valid=1, counter=1, state=BUSY.
  - Latency is 1 cycle from req sampled to grant visible.
- BUSY release conditions, evaluated each edge in priority order:
  1. req[sel]==0 (requester dropped), release.
  2. done==1, release.
  3. counter==MAX_HOLD, release and pulse expired=1 for 1 cycle.
  - If none applies, counter increments and the grant holds.
- On release:
  - ptr = sel+1 mod 32 (wraps from 31 to 0).
  - grant=0, valid=0, state=IDLE.
  - sel holds its last value.
  - Exactly one idle bubble cycle always follows before the next grant, even with pending requests.
- Simultaneous done and counter==MAX_HOLD: treated as a normal release; expired stays 0.
- done while in IDLE: ignored.
- Changes to req bits other than the owner's during BUSY: no effect until the next arbitration.
- grant is always one-hot or zero. sel only changes on the edge that asserts a new grant.
- data = mux_out & valid, combinational.
- Reset mid-grant: outputs return to reset values immediately (asynchronously); ptr returns to 0.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, and expired pulses unless done or a dropped req releases first.

Test Plan:
1. Reset then req=0x0000_0001 held, done never -> grant=0x1, sel=0 one cycle after req; after 8 valid cycles expired=1, grant=0; 1 idle cycle; re-grant to requester 0.
2. req=0x8000_0001 held, done pulsed after each grant's 2nd cycle -> grant order 0, 31, 0, 31, each grant 2 cycles, 1 bubble between grants.
3. Pointer wrap: grant requester 31 and release, then req=0x0000_0006 -> next grant is requester 1 (sel=1), then requester 2.
4. Owner drops req mid-tenure: requester 5 granted, req[5] cleared at counter=3 -> grant=0 next edge, expired=0, ptr=6.
5. Data path: requester 7 granted, mux_out toggled 0,1,1,0 -> data follows exactly; when idle, data=0 with mux_out=1.
6. Async reset asserted while requester 12 holds the grant (counter=4) -> grant=0, valid=0, sel=0 without a clock edge; after release with req=0x0000_1001, requester 0 wins (ptr=0).
